// File: rtl/btn_event_queue.sv
`default_nettype none
// ============================================================================
//  Module   : btn_event_queue
//  Brief    : Push-button event controller. Synchronises and debounces each
//             button, arbitrates presses into one timestamped stream, queues
//             the events in a small FIFO drained over an Avalon-MM slave and
//             raises a level interrupt while events are pending.
//  Revision : 1.0  initial release
// ============================================================================
module btn_event_queue #(
  parameter int NUM_BTN         = 3,      // 1..4
  parameter bit ACTIVE_LOW      = 1'b1,   // 1: pin low means pressed
  parameter int DEBOUNCE_CYCLES = 50000,  // 2..65535
  parameter int FIFO_DEPTH      = 8       // power of 2, 2..16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_BTN-1:0] in_port,
  input  logic [1:0]         address,
  input  logic               chipselect,
  input  logic               read_n,
  input  logic               write_n,
  input  logic [31:0]        writedata,
  output logic [31:0]        readdata,
  output logic               irq
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int                 PTR_W    = $clog2(FIFO_DEPTH);
  localparam int                 CNT_W    = 5;
  localparam int                 ENTRY_W  = 19;  // {overflow, index[1:0], timestamp[15:0]}
  localparam logic [15:0]        DB_LAST  = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   DEPTH_C  = CNT_W'(FIFO_DEPTH);
  // Synchroniser flops start at the released pin level so that leaving reset
  // never looks like the start of a press.
  localparam logic [NUM_BTN-1:0] PIN_IDLE = ACTIVE_LOW ? '1 : '0;

  // --------------------------------------------------------------------------
  // Input path and debounce state
  // --------------------------------------------------------------------------
  logic [NUM_BTN-1:0] sync1_q, sync1_d;
  logic [NUM_BTN-1:0] sync2_q, sync2_d;
  logic [NUM_BTN-1:0] level;
  logic [15:0]        db_cnt_q [NUM_BTN];
  logic [15:0]        db_cnt_d [NUM_BTN];
  logic [NUM_BTN-1:0] stable_q, stable_d;
  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] pending_q, pending_d;

  // --------------------------------------------------------------------------
  // Bus decode
  // --------------------------------------------------------------------------
  logic rd_acc;
  logic wr_acc;
  logic pop;
  logic flush;
  logic ovf_clr;

  // --------------------------------------------------------------------------
  // Arbiter
  // --------------------------------------------------------------------------
  logic               push_req;
  logic [1:0]         push_idx;
  logic [NUM_BTN-1:0] push_mask;

  // --------------------------------------------------------------------------
  // Timestamp, FIFO and register state
  // --------------------------------------------------------------------------
  logic [15:0]        ts_q, ts_d;
  logic [ENTRY_W-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               push_do;
  logic               fifo_empty;
  logic               fifo_full;
  logic [ENTRY_W-1:0] head_entry;
  logic [31:0]        head_word;
  logic               irq_en_q, irq_en_d;
  logic               irq_q, irq_d;
  logic [31:0]        readdata_q, readdata_d;

  // Only the two control bits of writedata are ever decoded.
  logic unused_wdata;
  assign unused_wdata = &{1'b0, writedata[31:2]};

  // 2-flop synchroniser feeding the debouncers; polarity is normalised so
  // that 1 always means pressed from here on.
  always_comb begin
    sync1_d = in_port;
    sync2_d = sync1_q;
    level   = ACTIVE_LOW ? ~sync2_q : sync2_q;
  end

  // Per-button debounce: a level change is accepted only after it has been
  // seen on DEBOUNCE_CYCLES consecutive clocks; any return to the stable
  // level restarts the count.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NUM_BTN; i++) begin
      db_cnt_d[i] = '0;
      if (level[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          stable_d[i] = level[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 16'd1;
        end
      end
    end
    rise = stable_d & ~stable_q;
  end

  // Avalon strobes and the side effects they trigger in the access cycle.
  always_comb begin
    rd_acc     = chipselect & ~read_n;
    wr_acc     = chipselect & ~write_n;
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == DEPTH_C);
    pop        = rd_acc & (address == 2'd1) & ~fifo_empty;
    flush      = wr_acc & (address == 2'd3) & writedata[0];
    ovf_clr    = wr_acc & (address == 2'd3) & writedata[1];
  end

  // Fixed-priority arbiter: lowest-index pending button wins. A flush
  // suppresses the push because it discards everything pending anyway.
  always_comb begin
    push_idx = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        push_idx = 2'(i);
      end
    end
    push_mask = pending_q & (~pending_q + NUM_BTN'(1));
    push_req  = (|pending_q) & ~flush;
    // A press landing on a bit that is being pushed this cycle re-arms it,
    // while a press on an already pending bit simply merges.
    pending_d = flush ? '0 : ((pending_q & ~push_mask) | rise);
  end

  // FIFO bookkeeping. A pop in the same cycle frees the slot a push into a
  // full queue needs, so only a push into a full queue without a pop drops.
  // A new drop takes priority over a simultaneous overflow clear.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q & ~ovf_clr;
    push_do    = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_req) begin
        if (fifo_full && !pop) begin
          overflow_d = 1'b1;
        end else begin
          push_do = 1'b1;
        end
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push_do) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      case ({push_do, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Head-of-queue word as the CPU sees it; an empty queue reads as zero.
  always_comb begin
    head_entry = fifo_mem_q[rd_ptr_q];
    head_word  = '0;
    if (!fifo_empty) begin
      head_word = {1'b1, head_entry[18], 12'd0, head_entry[17:16], head_entry[15:0]};
    end
  end

  // Register file next state: read mux, irq enable and the interrupt level.
  // readdata holds its value between read accesses.
  always_comb begin
    ts_d       = ts_q + 16'd1;
    irq_en_d   = irq_en_q;
    irq_d      = irq_en_q & ~fifo_empty;
    readdata_d = readdata_q;
    if (wr_acc && (address == 2'd2)) begin
      irq_en_d = writedata[0];
    end
    if (rd_acc) begin
      case (address)
        2'd0:    readdata_d = {{(32 - NUM_BTN){1'b0}}, stable_q};
        2'd1:    readdata_d = head_word;
        2'd2:    readdata_d = {31'd0, irq_en_q};
        default: readdata_d = {22'd0, fifo_full, overflow_q, 3'd0, count_q};
      endcase
    end
  end

  // Input, debounce and pending state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= PIN_IDLE;
      sync2_q   <= PIN_IDLE;
      stable_q  <= '0;
      pending_q <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      stable_q  <= stable_d;
      pending_q <= pending_d;
      for (int i = 0; i < NUM_BTN; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  // Queue control, timestamp and register-file state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      irq_en_q   <= 1'b0;
      irq_q      <= 1'b0;
      readdata_q <= '0;
    end else begin
      ts_q       <= ts_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_d;
      readdata_q <= readdata_d;
    end
  end

  // Event storage; contents are only meaningful between the pointers, so
  // the array itself needs no reset.
  always_ff @(posedge clk) begin
    if (push_do) begin
      fifo_mem_q[wr_ptr_q] <= {overflow_q, push_idx, ts_q};
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_btn_event_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_btn_event_queue
//  Brief    : Self-checking bench for btn_event_queue: directed scenarios
//             plus randomised pins and bus traffic compared every cycle
//             against a queue-based behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_btn_event_queue;

  localparam int NB = 3;
  localparam int DB = 16;
  localparam int FD = 8;

  logic          clk        = 1'b0;
  logic          reset_n    = 1'b0;
  logic [NB-1:0] in_port    = '1;
  logic [1:0]    address    = '0;
  logic          chipselect = 1'b0;
  logic          read_n     = 1'b1;
  logic          write_n    = 1'b1;
  logic [31:0]   writedata  = '0;
  logic [31:0]   readdata;
  logic          irq;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  btn_event_queue #(
    .NUM_BTN        (NB),
    .ACTIVE_LOW     (1'b1),
    .DEBOUNCE_CYCLES(DB),
    .FIFO_DEPTH     (FD)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_port   (in_port),
    .address   (address),
    .chipselect(chipselect),
    .read_n    (read_n),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .irq       (irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: pin history queue, per-button run lengths, a queue
  // of event words and the visible register values.
  // --------------------------------------------------------------------------
  logic [NB-1:0] m_hist[$];
  logic [NB-1:0] m_stable;
  logic [NB-1:0] m_pending;
  int            m_run[NB];
  logic [31:0]   m_fifo[$];
  logic          m_ovf;
  logic          m_irq_en;
  logic          m_irq;
  logic [15:0]   m_ts;
  logic [31:0]   m_rd;

  always @(posedge clk or negedge reset_n) begin : p_model
    logic [NB-1:0] lvl;
    logic [NB-1:0] new_stable;
    logic [NB-1:0] pressed_now;
    logic [31:0]   rdv;
    logic [31:0]   word;
    bit            rd, wr, flush, clr, drop;
    int            pidx;
    int            size0;
    if (!reset_n) begin
      m_hist.delete();
      m_hist.push_back('1);
      m_hist.push_back('1);
      m_stable  = '0;
      m_pending = '0;
      for (int i = 0; i < NB; i++) m_run[i] = 0;
      m_fifo.delete();
      m_ovf    = 1'b0;
      m_irq_en = 1'b0;
      m_irq    = 1'b0;
      m_ts     = '0;
      m_rd     = '0;
    end else begin
      // pins reach the debouncer two clocks late and inverted
      lvl = ~m_hist.pop_front();
      m_hist.push_back(in_port);
      new_stable  = m_stable;
      pressed_now = '0;
      for (int i = 0; i < NB; i++) begin
        if (lvl[i] != m_stable[i]) begin
          m_run[i]++;
          if (m_run[i] == DB) begin
            new_stable[i] = lvl[i];
            m_run[i]      = 0;
            if (lvl[i]) pressed_now[i] = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      rd    = chipselect && !read_n;
      wr    = chipselect && !write_n;
      size0 = m_fifo.size();
      rdv   = '0;
      case (address)
        2'd0: rdv = 32'(m_stable);
        2'd1: rdv = (size0 > 0) ? m_fifo[0] : 32'd0;
        2'd2: rdv = 32'(m_irq_en);
        default: rdv = ((size0 == FD) ? 32'h200 : 32'h0) | (m_ovf ? 32'h100 : 32'h0) | 32'(size0);
      endcase
      m_irq = m_irq_en && (size0 != 0);
      flush = wr && (address == 2'd3) && writedata[0];
      clr   = wr && (address == 2'd3) && writedata[1];
      drop  = 1'b0;
      pidx  = -1;
      for (int i = 0; i < NB; i++) if (m_pending[i] && pidx < 0) pidx = i;
      if (flush) begin
        m_fifo.delete();
        m_pending = '0;
      end else begin
        if (rd && address == 2'd1 && size0 > 0) void'(m_fifo.pop_front());
        if (pidx >= 0) begin
          m_pending[pidx] = 1'b0;
          word = {1'b1, m_ovf, 12'd0, 2'(pidx), m_ts};
          if (m_fifo.size() < FD) m_fifo.push_back(word);
          else drop = 1'b1;
        end
        m_pending = m_pending | pressed_now;
      end
      m_ovf    = (m_ovf && !clr) || drop;
      if (wr && address == 2'd2) m_irq_en = writedata[0];
      m_stable = new_stable;
      m_ts     = m_ts + 16'd1;
      if (rd) m_rd = rdv;
    end
  end

  // Cycle-by-cycle comparison of the visible outputs against the model.
  always @(negedge clk) begin
    if (reset_n) begin
      check("readdata", readdata, m_rd);
      check("irq", 32'(irq), 32'(m_irq));
    end
  end

  // --------------------------------------------------------------------------
  // Bus and pin helpers
  // --------------------------------------------------------------------------
  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; read_n = 1'b0;
    @(negedge clk);
    d = readdata;
    chipselect = 1'b0; read_n = 1'b1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic press(input int b);
    @(negedge clk);
    in_port[b] = 1'b0;
    repeat (DB + 5) @(negedge clk);
    in_port[b] = 1'b1;
    repeat (DB + 5) @(negedge clk);
  endtask

  logic [31:0] d, d1, d2;
  logic [15:0] ts1, ts2;

  initial begin
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    bus_read(2'd3, d); check("reset_status", d, 32'h0);
    bus_read(2'd2, d); check("reset_irq_en", d, 32'h0);

    // Long press on button 0 yields exactly one event.
    @(negedge clk);
    in_port[0] = 1'b0;
    repeat (DB + 5) @(negedge clk);
    bus_read(2'd3, d); check("t1_count", d, 32'h1);
    bus_read(2'd0, d); check("t1_state", d, 32'h1);
    bus_read(2'd1, d); check("t1_event_hi", d & 32'hFFFF_0000, 32'h8000_0000);
    bus_read(2'd3, d); check("t1_count_after", d, 32'h0);
    in_port[0] = 1'b1;
    repeat (DB + 5) @(negedge clk);

    // A 10-clock glitch on button 1 is filtered out.
    in_port[1] = 1'b0;
    repeat (10) @(negedge clk);
    in_port[1] = 1'b1;
    repeat (DB + 5) @(negedge clk);
    bus_read(2'd0, d); check("t2_state", d, 32'h0);
    bus_read(2'd3, d); check("t2_count", d, 32'h0);

    // Buttons 0 and 2 accepted together: index 0 first, timestamps 1 apart.
    in_port[0] = 1'b0; in_port[2] = 1'b0;
    repeat (DB + 5) @(negedge clk);
    bus_read(2'd1, d1);
    bus_read(2'd1, d2);
    check("t3_first_idx", (d1 >> 16) & 32'h3, 32'h0);
    check("t3_second_idx", (d2 >> 16) & 32'h3, 32'h2);
    ts1 = d1[15:0]; ts2 = d2[15:0];
    check("t3_ts_delta", 32'(16'(ts2 - ts1)), 32'h1);
    in_port[0] = 1'b1; in_port[2] = 1'b1;
    repeat (DB + 5) @(negedge clk);

    // Nine presses into an eight-deep queue overflow it.
    for (int k = 0; k < 9; k++) press(0);
    bus_read(2'd3, d); check("t4_full_ovf", d, 32'h308);
    bus_write(2'd3, 32'h2);
    bus_read(2'd3, d); check("t4_ovf_clear", d, 32'h208);
    bus_write(2'd3, 32'h1);
    bus_read(2'd3, d); check("t4_flush", d, 32'h0);

    // Interrupt follows queue occupancy when enabled.
    bus_write(2'd2, 32'h1);
    bus_read(2'd2, d); check("t5_irq_en", d, 32'h1);
    press(1);
    check("t5_irq_set", 32'(irq), 32'h1);
    bus_read(2'd1, d); check("t5_event_hi", d & 32'hFFFF_0000, 32'h8001_0000);
    repeat (2) @(negedge clk);
    check("t5_irq_clr_pop", 32'(irq), 32'h0);
    press(0);
    press(2);
    check("t5_irq_two", 32'(irq), 32'h1);
    bus_write(2'd3, 32'h1);
    repeat (2) @(negedge clk);
    check("t5_irq_clr_flush", 32'(irq), 32'h0);
    bus_read(2'd3, d); check("t5_count_flush", d, 32'h0);

    // Reset mid-operation discards everything immediately.
    for (int k = 0; k < 3; k++) press(k);
    bus_read(2'd3, d); check("t6_count", d, 32'h3);
    check("t6_irq_before", 32'(irq), 32'h1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("t6_rst_readdata", readdata, 32'h0);
    check("t6_rst_irq", 32'(irq), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    bus_read(2'd2, d); check("t6_irq_en", d, 32'h0);
    bus_read(2'd3, d); check("t6_count_after", d, 32'h0);

    // Randomised pins and bus traffic, checked every cycle by the model.
    bus_write(2'd2, 32'h1);
    fork
      begin : p_pins
        int hold[NB];
        for (int i = 0; i < NB; i++) hold[i] = 0;
        for (int c = 0; c < 4000; c++) begin
          @(negedge clk);
          for (int i = 0; i < NB; i++) begin
            if (hold[i] == 0) begin
              in_port[i] = 1'($urandom);
              hold[i] = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 12) : $urandom_range(17, 45);
            end else begin
              hold[i]--;
            end
          end
        end
        in_port = '1;
      end
      begin : p_bus
        logic [31:0] rdat;
        logic [31:0] wdat;
        logic [1:0]  a;
        for (int n = 0; n < 1200; n++) begin
          case ($urandom_range(0, 9))
            0, 1, 2: begin
              a = 2'($urandom_range(0, 3));
              bus_read(a, rdat);
            end
            3: begin
              a    = 2'($urandom_range(0, 3));
              wdat = $urandom;
              if (a == 2'd3) wdat[0] = ($urandom_range(0, 7) == 0);
              bus_write(a, wdat);
            end
            default: repeat ($urandom_range(1, 4)) @(negedge clk);
          endcase
        end
      end
    join
    repeat (60) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/btn_event_queue.md
Name: btn_event_queue

Overview:
- Memory-mapped button event controller for the Nios system. It sits between the raw push-button pins and the CPU, replacing plain edge-capture polling.
- Each button is synchronised and debounced. Every debounced press is arbitrated into a single stream and timestamped.
- Events are queued in a small FIFO that the CPU drains over an Avalon-MM slave. An interrupt is raised while events are pending.

Parameters:
- NUM_BTN, 3, number of buttons (1..4).
- ACTIVE_LOW, 1, 1 = a pin at 0 means pressed.
- DEBOUNCE_CYCLES, 50000, consecutive stable clocks required to accept a level change (2..65535).
- FIFO_DEPTH, 8, event FIFO entries (power of 2, 2..16).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- in_port  in  NUM_BTN  raw button pins, asynchronous to clk.
- address  in  2  Avalon word address.
- chipselect  in  1  slave select.
- read_n  in  1  active-low read strobe.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- irq  out  1  level interrupt.

Behaviour:
- Clock and reset:
  - One clock, clk. Reset is asynchronous and active-low on reset_n.
  - Every register clears on reset: readdata=0, irq=0, FIFO empty, overflow=0, irq_en=0, timestamp=0, pending=0, debounced state=released.
  - Reset asserted mid-operation discards all queued and pending events.
- Input path:
  - in_port passes through a 2-flop synchroniser, then is inverted when ACTIVE_LOW=1.
- Debounce (per button):
  - A 16-bit counter clears whenever the synchronised level equals the stable level.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, stable takes the new level and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES clocks produces no change.
- Press detect:
  - A 0->1 transition of stable sets pending[i] in the same cycle.
  - A new press on a button whose pending bit is already set merges into it and produces no second event.
- Arbiter:
  - Each cycle, the lowest-index set pending bit is pushed into the FIFO and that bit clears. At most one push per cycle.
  - Event word: bit31=1 (valid), bit30=overflow flag at push time, bits[17:16]=button index, bits[15:0]=timestamp.
- Timestamp:
  - 16-bit free-running counter, increments every clk and wraps 0xFFFF->0.
  - The value captured is the one in the push cycle.
- FIFO:
  - Push while full: event dropped, pending bit still cleared, sticky overflow set.
  - Push and pop in the same cycle while full: both occur, no overflow.
  - Pop while empty: no state change.
- Register map (readdata updates 1 clock after the access cycle):
  - addr0 R: bits[NUM_BTN-1:0]=debounced states.
  - addr1 R: FIFO head word, or 0 if empty. A read with chipselect & ~read_n pops the head in the access cycle and returns the pre-pop head.
  - addr2 RW: bit0=irq_en.
  - addr3 R: bits[4:0]=count, bit8=overflow, bit9=full. Write with bit0=1 flushes the FIFO; write with bit1=1 clears overflow. A flush also clears pending.
  - Unused bits read 0. Writes to read-only addresses are ignored.
- Interrupt:
  - irq is registered: irq = irq_en & (count != 0), one clock after the state changes.

Test Plan:
- Hold in_port[0] low (pressed) for DEBOUNCE_CYCLES+5 clocks with DEBOUNCE_CYCLES=16 -> count=1; addr1 read returns 0x8000_0000 | timestamp; count then 0.
- Pulse in_port[1] low for 10 clocks with DEBOUNCE_CYCLES=16 -> no event, addr0 bit1 stays 0, count=0.
- Buttons 2 and 0 accepted in the same cycle -> two events, index 0 then index 2, timestamps differing by 1.
- 9 presses with FIFO_DEPTH=8, no reads -> count=8, full=1, overflow=1; write 0x2 to addr3 -> overflow=0, count still 8.
- Set irq_en=1, then one press -> irq=1 one clock after push; pop the event -> irq=0 one clock after pop; write 0x1 to addr3 with events queued -> count=0, irq=0.
- Assert reset_n=0 for one cycle with 3 events queued -> readdata=0, count=0, irq=0, irq_en=0 immediately.
